// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation codes and default iteration count.
package mult_div_ctrl_pkg;

    localparam int ITER_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4,
        ST_DZERO = 3'd5
    } state_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Control-unit <-> mult/div sequencer signal bundle. The control unit is the
// master; the sequencer is the slave.
interface mult_div_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic             md_control;
    logic [31:0]      regB_out;
    logic             abort;
    logic             md_op;
    logic             md_init;
    logic             md_step;
    logic [CNT_W-1:0] step_count;
    logic             hi_write;
    logic             lo_write;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, md_control, regB_out, abort,
        input  md_op, md_init, md_step, step_count,
        input  hi_write, lo_write, busy, done, div_zero
    );

    modport slave (
        input  start, md_control, regB_out, abort,
        output md_op, md_init, md_step, step_count,
        output hi_write, lo_write, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl_counter.sv
// Iteration step counter: synchronous clear, count enable, and a terminal
// count flag that also freezes the count at ITER-1.
module mult_div_counter #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(ITER - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer: steps the datapath through load, ITER iterations
// and HI/LO write-back, trapping division by zero before any iteration.
//
//   state | meaning
//   IDLE  | waiting for start
//   INIT  | datapath loads operands, counter cleared
//   RUN   | one datapath iteration per cycle
//   WRITE | HI/LO write enables
//   FIN   | done pulse
//   DZERO | div-by-zero trap: done + div_zero, no write-back
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    mult_div_ctrl_if.slave   md
);

    state_t state;
    state_t state_nxt;
    logic   md_op_q;
    logic   cnt_clear;
    logic   cnt_en;
    logic   cnt_tc;

    mult_div_counter #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (md.step_count),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            md_op_q <= MD_MULT;
        end else if (state == ST_IDLE && md.start && !md.abort) begin
            md_op_q <= md.md_control;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
                if (md.start && !md.abort) begin
                    if (md.md_control == MD_DIV && md.regB_out == 32'd0) begin
                        state_nxt = ST_DZERO;
                    end else begin
                        state_nxt = ST_INIT;
                    end
                end
            end
            ST_INIT: begin
                cnt_clear = 1'b1;
                state_nxt = md.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (md.abort) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_en    = 1'b1;
                    state_nxt = cnt_tc ? ST_WRITE : ST_RUN;
                end
            end
            ST_WRITE: state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            ST_DZERO: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore decode; md_op and step_count come straight from registers
    assign md.md_op    = md_op_q;
    assign md.md_init  = (state == ST_INIT);
    assign md.md_step  = (state == ST_RUN);
    assign md.hi_write = (state == ST_WRITE);
    assign md.lo_write = (state == ST_WRITE);
    assign md.busy     = (state != ST_IDLE);
    assign md.done     = (state == ST_FIN) || (state == ST_DZERO);
    assign md.div_zero = (state == ST_DZERO);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: stimulus queues the expected output
// events per cycle, a negedge monitor pops and compares them.
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    logic clock = 1'b0;
    logic reset;

    mult_div_ctrl_if #(.CNT_W(CNT_W)) md ();

    mult_div_ctrl #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .md    (md)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic             init;
        logic             step;
        logic [CNT_W-1:0] cnt;
        logic             wr;
        logic             dn;
        logic             dz;
        logic             op;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic push(int c, logic init, logic step, int cnt,
                        logic wr, logic dn, logic dz, logic op);
        ev_t e;
        e.cyc  = c;
        e.init = init;
        e.step = step;
        e.cnt  = CNT_W'(cnt);
        e.wr   = wr;
        e.dn   = dn;
        e.dz   = dz;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    // Expected events for a start sampled at the edge closing cycle e
    task automatic push_op(int e, logic op, logic dz_case);
        if (dz_case) begin
            push(e + 1, 0, 0, 0, 0, 1, 1, op);
        end else begin
            push(e + 1, 1, 0, 0, 0, 0, 0, op);
            for (int i = 0; i < ITER; i++) push(e + 2 + i, 0, 1, i, 0, 0, 0, op);
            push(e + ITER + 2, 0, 0, 0, 1, 0, 0, op);
            push(e + ITER + 3, 0, 0, 0, 0, 1, 0, op);
        end
    endtask

    task automatic push_partial(int e, logic op, int last_step);
        push(e + 1, 1, 0, 0, 0, 0, 0, op);
        for (int i = 0; i <= last_step; i++) push(e + 2 + i, 0, 1, i, 0, 0, 0, op);
    endtask

    // Monitor: every cycle with datapath activity must match the queue head
    ev_t got_e;
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_event: expected activity at cycle %0d, still absent at cycle %0d",
                     exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (md.md_init | md.md_step | md.hi_write | md.lo_write | md.done | md.div_zero) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d init=%b step=%b hi=%b lo=%b done=%b dz=%b, required no activity",
                         cyc, md.md_init, md.md_step, md.hi_write, md.lo_write, md.done, md.div_zero);
            end else begin
                got_e = exp_q.pop_front();
                if (got_e.cyc != cyc || md.md_init !== got_e.init || md.md_step !== got_e.step ||
                    (got_e.step && md.step_count !== got_e.cnt) ||
                    md.hi_write !== got_e.wr || md.lo_write !== got_e.wr ||
                    md.done !== got_e.dn || md.div_zero !== got_e.dz ||
                    md.md_op !== got_e.op || md.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL event: got cyc=%0d init=%b step=%b cnt=%0d hi=%b lo=%b done=%b dz=%b op=%b busy=%b, required cyc=%0d init=%b step=%b cnt=%0d hi=%b lo=%b done=%b dz=%b op=%b busy=1",
                             cyc, md.md_init, md.md_step, md.step_count, md.hi_write, md.lo_write,
                             md.done, md.div_zero, md.md_op, md.busy,
                             got_e.cyc, got_e.init, got_e.step, got_e.cnt, got_e.wr, got_e.wr,
                             got_e.dn, got_e.dz, got_e.op);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Called at a negedge: start is high for exactly the current cycle
    task automatic start_op(logic ctl, logic [31:0] b);
        md.start      = 1'b1;
        md.md_control = ctl;
        md.regB_out   = b;
        @(negedge clock);
        md.start      = 1'b0;
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_busy"},  md.busy,       0);
        chk({tag, "_init"},  md.md_init,    0);
        chk({tag, "_step"},  md.md_step,    0);
        chk({tag, "_hi"},    md.hi_write,   0);
        chk({tag, "_lo"},    md.lo_write,   0);
        chk({tag, "_done"},  md.done,       0);
        chk({tag, "_dz"},    md.div_zero,   0);
        chk({tag, "_cnt"},   md.step_count, 0);
        chk({tag, "_md_op"}, md.md_op,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e;
    initial begin
        reset         = 1'b1;
        md.start      = 1'b0;
        md.md_control = 1'b0;
        md.regB_out   = 32'd0;
        md.abort      = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_quiet("reset");
        @(negedge clock);

        // Mult: full sequence, busy window 1..35
        e = cyc;
        push_op(e, MD_MULT, 1'b0);
        start_op(MD_MULT, 32'd5);
        chk("mult_busy_c1", md.busy, 1);
        wait_until(e + 35);
        chk("mult_busy_c35", md.busy, 1);
        wait_until(e + 36);
        chk("mult_busy_c36", md.busy, 0);
        repeat (2) @(negedge clock);

        // Div by zero: one-cycle trap
        e = cyc;
        push_op(e, MD_DIV, 1'b1);
        start_op(MD_DIV, 32'd0);
        chk("dz_busy_c1", md.busy, 1);
        @(negedge clock);
        chk("dz_busy_c2", md.busy, 0);
        repeat (3) @(negedge clock);

        // Start together with abort in IDLE is dropped
        md.abort = 1'b1;
        start_op(MD_MULT, 32'd4);
        md.abort = 1'b0;
        chk("start_abort_busy", md.busy, 0);
        repeat (3) @(negedge clock);

        // Abort in RUN at step_count 10, then 40 quiet cycles
        e = cyc;
        push_partial(e, MD_MULT, 10);
        start_op(MD_MULT, 32'd6);
        wait_until(e + 12);
        md.abort = 1'b1;
        @(negedge clock);
        md.abort = 1'b0;
        chk("abort_busy", md.busy, 0);
        chk("abort_cnt", md.step_count, 0);
        wait_until(e + 53);

        // Div with stray starts at cycles 5 and 20, then back-to-back mult
        e = cyc;
        push_op(e, MD_DIV, 1'b0);
        start_op(MD_DIV, 32'd7);
        md.md_control = MD_MULT;
        md.regB_out   = 32'd0;
        wait_until(e + 5);
        start_op(MD_MULT, 32'd0);
        wait_until(e + 20);
        start_op(MD_MULT, 32'd0);
        wait_until(e + 35);
        chk("stray_md_op", md.md_op, 1);
        wait_until(e + 36);
        e = cyc;
        push_op(e, MD_MULT, 1'b0);
        start_op(MD_MULT, 32'd9);
        chk("b2b_md_op", md.md_op, 0);
        wait_until(e + 36);
        chk("b2b_idle", md.busy, 0);

        // Reset in the middle of RUN at step_count 17, then a fresh div
        e = cyc;
        push_partial(e, MD_MULT, 17);
        start_op(MD_MULT, 32'd5);
        wait_until(e + 19);
        chk("pre_reset_cnt", md.step_count, 17);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_quiet("midrst");
        @(negedge clock);
        e = cyc;
        push_op(e, MD_DIV, 1'b0);
        start_op(MD_DIV, 32'd3);
        wait_until(e + 2);
        chk("restart_cnt", md.step_count, 0);
        wait_until(e + 38);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
